hazard_detection_unit: RTL and testbench
========================================

HAZARD_DETECTION_UNIT -- requirements
Module: hazard_detection_unit

Interface
REQ-001 SHALL have parameter CNT_W, default 16, the width of the event counters.
REQ-002 SHALL have port clk, input, 1 bit: the single pipeline clock; all state updates occur on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
REQ-004 SHALL have ports IF_ID_rs1 and IF_ID_rs2, inputs, 5 bits each: source registers of the instruction in ID.
REQ-005 SHALL have port IF_ID_uses_rs2, input, 1 bit: 1 when the ID instruction reads rs2.
REQ-006 SHALL have port ID_EX_rd, input, 5 bits: destination register of the instruction in EX.
REQ-007 SHALL have port ID_EX_MemRead, input, 1 bit: the EX instruction is a load.
REQ-008 SHALL have port Branch_Taken, input, 1 bit: a branch or jump resolved taken in EX.
REQ-009 SHALL have port Mem_Busy, input, 1 bit: data memory not ready; the pipeline is frozen.
REQ-010 SHALL have port PC_Write, output, 1 bit: PC update enable.
REQ-011 SHALL have ports IF_ID_Write, ID_EX_Write and EX_MEM_Write, outputs, 1 bit each: pipeline register enables.
REQ-012 SHALL have port ID_EX_Bubble, output, 1 bit: zero the control signals entering ID/EX.
REQ-013 SHALL have ports IF_ID_Flush and ID_EX_Flush, outputs, 1 bit each: squash the contents of IF/ID and ID/EX.
REQ-014 SHALL have port state, output, 2 bits: current FSM state.
REQ-015 SHALL have ports stall_count and flush_count, outputs, CNT_W bits each: event counters.
REQ-016 SHALL have port hazard_error, output, 1 bit: sticky protocol-violation flag.

Function
REQ-017 SHALL define load_use = ID_EX_MemRead && ID_EX_rd!=0 && (ID_EX_rd==IF_ID_rs1 || (IF_ID_uses_rs2 && ID_EX_rd==IF_ID_rs2)).
REQ-018 SHALL select exactly one action per cycle, in priority order: FREEZE (Mem_Busy), FLUSH (Branch_Taken), STALL (load_use), otherwise NONE.
REQ-019 SHALL drive outputs for FREEZE as: PC_Write=0, IF_ID_Write=0, ID_EX_Write=0, EX_MEM_Write=0, Bubble=0, both Flush=0.
REQ-020 SHALL drive outputs for FLUSH as: PC_Write=1, IF_ID_Write=1, ID_EX_Write=1, EX_MEM_Write=1, IF_ID_Flush=1, ID_EX_Flush=1, Bubble=0.
REQ-021 SHALL drive outputs for STALL as: PC_Write=0, IF_ID_Write=0, ID_EX_Write=1, EX_MEM_Write=1, ID_EX_Bubble=1, both Flush=0.
REQ-022 SHALL drive outputs for NONE as: all Write enables=1, Bubble=0, both Flush=0.
REQ-023 SHALL make the control outputs combinational from the inputs and state, with zero-cycle latency.
REQ-024 SHALL encode state as RUN=00, LOAD_STALL=01, FLUSH=10, MEM_WAIT=11.
REQ-025 SHALL load next state on each clock edge from the action taken: FREEZE->MEM_WAIT, FLUSH->FLUSH, STALL->LOAD_STALL, NONE->RUN; these transitions are legal from any state.
REQ-026 SHALL increment stall_count on each STALL cycle and flush_count on each FLUSH cycle, saturating at all-ones with no wrap.
REQ-027 SHALL NOT count a Branch_Taken or load_use that is masked by FREEZE; the held condition is counted once, on the cycle after Mem_Busy deasserts.
REQ-028 SHALL set hazard_error on a clock edge where action=STALL and state is LOAD_STALL or FLUSH, since a bubble in EX cannot be a load.
REQ-029 SHALL hold hazard_error at 1 until reset once it is set.
REQ-030 SHALL leave load_use unasserted when ID_EX_rd=0, regardless of ID_EX_MemRead.
REQ-031 SHALL let Branch_Taken override a coincident load_use: the result is a FLUSH, stall_count is unchanged and flush_count increments by 1.

Reset
REQ-032 SHALL, while reset=0, asynchronously force state=RUN, stall_count=0, flush_count=0 and hazard_error=0.
REQ-033 SHALL, while reset=0, force PC_Write=0, all Write enables=0, ID_EX_Bubble=1 and both Flush=0.
REQ-034 SHALL, on reset asserted mid-STALL or mid-FREEZE, abandon the action immediately; after reset release the first cycle is evaluated from RUN.

Verification
REQ-035 SHALL check: ID_EX_MemRead=1, ID_EX_rd=5, IF_ID_rs1=5 -> PC_Write=0, IF_ID_Write=0, Bubble=1; next cycle state=01, stall_count=1.
REQ-036 SHALL check: the same load with IF_ID_rs2=5 and IF_ID_uses_rs2=0 -> NONE; with ID_EX_rd=0 -> NONE.
REQ-037 SHALL check: Branch_Taken=1 together with load_use=1 -> both Flush=1, PC_Write=1; next cycle state=10, flush_count=1, stall_count=0.
REQ-038 SHALL check: Mem_Busy=1 for 3 cycles with Branch_Taken=1 -> all Write enables=0 and state=11 throughout; on release, one FLUSH and flush_count=1.
REQ-039 SHALL check: load_use forced for 2 consecutive cycles -> hazard_error=1 after the 2nd edge, held until reset=0.
REQ-040 SHALL check: with CNT_W=4, 17 STALL cycles -> stall_count holds at 15; reset=0 asserted mid-run clears all counters and state asynchronously.

Source files
------------

// File: rtl/hazard_detection_unit_if.sv
// Pipeline hazard control bundle: ID/EX hazard inputs toward the unit and
// pipeline enables, flush/bubble controls and status back to the datapath.
interface hazard_detection_unit_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       IF_ID_rs1;
    logic [4:0]       IF_ID_rs2;
    logic             IF_ID_uses_rs2;
    logic [4:0]       ID_EX_rd;
    logic             ID_EX_MemRead;
    logic             Branch_Taken;
    logic             Mem_Busy;

    logic             PC_Write;
    logic             IF_ID_Write;
    logic             ID_EX_Write;
    logic             EX_MEM_Write;
    logic             ID_EX_Bubble;
    logic             IF_ID_Flush;
    logic             ID_EX_Flush;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;
    logic             hazard_error;

    modport master (
        output IF_ID_rs1, IF_ID_rs2, IF_ID_uses_rs2, ID_EX_rd, ID_EX_MemRead,
               Branch_Taken, Mem_Busy,
        input  PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write, ID_EX_Bubble,
               IF_ID_Flush, ID_EX_Flush, state, stall_count, flush_count,
               hazard_error
    );

    modport slave (
        input  IF_ID_rs1, IF_ID_rs2, IF_ID_uses_rs2, ID_EX_rd, ID_EX_MemRead,
               Branch_Taken, Mem_Busy,
        output PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write, ID_EX_Bubble,
               IF_ID_Flush, ID_EX_Flush, state, stall_count, flush_count,
               hazard_error
    );
endinterface

// File: rtl/hazard_detection_unit.sv
// Pipeline hazard controller: picks one of FREEZE/FLUSH/STALL/NONE per cycle,
// drives pipeline enables combinationally and tracks state, counters, errors.
module hazard_detection_unit #(
    parameter int CNT_W = 16
) (
    input logic                    clk,
    input logic                    reset,
    hazard_detection_unit_if.slave hdu
);

    typedef enum logic [1:0] {
        RUN        = 2'b00,
        LOAD_STALL = 2'b01,
        FLUSH      = 2'b10,
        MEM_WAIT   = 2'b11
    } state_e;

    typedef enum logic [1:0] {
        ACT_NONE,
        ACT_STALL,
        ACT_FLUSH,
        ACT_FREEZE
    } action_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;
    logic             hazard_error_q, hazard_error_d;
    logic             load_use;
    action_e          action;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        load_use = hdu.ID_EX_MemRead && (hdu.ID_EX_rd != 5'd0) &&
                   ((hdu.ID_EX_rd == hdu.IF_ID_rs1) ||
                    (hdu.IF_ID_uses_rs2 && (hdu.ID_EX_rd == hdu.IF_ID_rs2)));
    end

    // Freeze masks everything, so a held branch/load-use is acted on only once
    // the memory releases the pipeline.
    always_comb begin
        action = ACT_NONE;
        if (hdu.Mem_Busy)          action = ACT_FREEZE;
        else if (hdu.Branch_Taken) action = ACT_FLUSH;
        else if (load_use)         action = ACT_STALL;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= RUN;
            stall_count_q  <= '0;
            flush_count_q  <= '0;
            hazard_error_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            stall_count_q  <= stall_count_d;
            flush_count_q  <= flush_count_d;
            hazard_error_q <= hazard_error_d;
        end
    end

    always_comb begin
        state_d = RUN;
        case (action)
            ACT_FREEZE: state_d = MEM_WAIT;
            ACT_FLUSH:  state_d = FLUSH;
            ACT_STALL:  state_d = LOAD_STALL;
            default:    state_d = RUN;
        endcase
    end

    // A stall right after a stall or flush means EX holds a bubble, which can
    // never be a load, so the inputs are inconsistent.
    always_comb begin
        stall_count_d  = (action == ACT_STALL) ? sat_inc(stall_count_q) : stall_count_q;
        flush_count_d  = (action == ACT_FLUSH) ? sat_inc(flush_count_q) : flush_count_q;
        hazard_error_d = hazard_error_q ||
                         ((action == ACT_STALL) &&
                          ((state_q == LOAD_STALL) || (state_q == FLUSH)));
    end

    always_comb begin
        hdu.PC_Write     = 1'b1;
        hdu.IF_ID_Write  = 1'b1;
        hdu.ID_EX_Write  = 1'b1;
        hdu.EX_MEM_Write = 1'b1;
        hdu.ID_EX_Bubble = 1'b0;
        hdu.IF_ID_Flush  = 1'b0;
        hdu.ID_EX_Flush  = 1'b0;
        if (!reset) begin
            hdu.PC_Write     = 1'b0;
            hdu.IF_ID_Write  = 1'b0;
            hdu.ID_EX_Write  = 1'b0;
            hdu.EX_MEM_Write = 1'b0;
            hdu.ID_EX_Bubble = 1'b1;
        end else begin
            case (action)
                ACT_FREEZE: begin
                    hdu.PC_Write     = 1'b0;
                    hdu.IF_ID_Write  = 1'b0;
                    hdu.ID_EX_Write  = 1'b0;
                    hdu.EX_MEM_Write = 1'b0;
                end
                ACT_FLUSH: begin
                    hdu.IF_ID_Flush = 1'b1;
                    hdu.ID_EX_Flush = 1'b1;
                end
                ACT_STALL: begin
                    hdu.PC_Write     = 1'b0;
                    hdu.IF_ID_Write  = 1'b0;
                    hdu.ID_EX_Bubble = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        hdu.state        = state_q;
        hdu.stall_count  = stall_count_q;
        hdu.flush_count  = flush_count_q;
        hdu.hazard_error = hazard_error_q;
    end

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Bench for hazard_detection_unit: directed scenarios plus random stimulus on a
// 16-bit and a 4-bit counter instance, checked against a rule-level model.
module tb_hazard_detection_unit;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_chk = 0;
    int   n_pass = 0;

    // model state: code of the last action taken (0 RUN,1 STALL,2 FLUSH,3 FREEZE)
    int   m_state = 0;
    int   m_stall = 0;
    int   m_flush = 0;
    int   m_err   = 0;

    always #5 clk = ~clk;

    hazard_detection_unit_if #(.CNT_W(16)) if16 ();
    hazard_detection_unit_if #(.CNT_W(4))  if4 ();

    hazard_detection_unit #(.CNT_W(16)) u_dut16 (.clk(clk), .reset(reset), .hdu(if16));
    hazard_detection_unit #(.CNT_W(4))  u_dut4  (.clk(clk), .reset(reset), .hdu(if4));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic int model_action(input logic [4:0] rs1, input logic [4:0] rs2,
                                        input logic uses, input logic [4:0] rd,
                                        input logic mr, input logic br, input logic busy);
        bit hit;
        hit = mr && rd != 0 && (rd == rs1 || (uses && rd == rs2));
        if (busy) return 3;
        if (br)   return 2;
        if (hit)  return 1;
        return 0;
    endfunction

    // {PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write, Bubble, IF_ID_Flush, ID_EX_Flush}
    function automatic logic [6:0] exp_ctl(input int a);
        case (a)
            3:       return 7'b0000_000;
            2:       return 7'b1111_011;
            1:       return 7'b0011_100;
            default: return 7'b1111_000;
        endcase
    endfunction

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic uses,
                         input logic [4:0] rd, input logic mr, input logic br, input logic busy);
        if16.IF_ID_rs1 = rs1; if16.IF_ID_rs2 = rs2; if16.IF_ID_uses_rs2 = uses;
        if16.ID_EX_rd = rd; if16.ID_EX_MemRead = mr; if16.Branch_Taken = br; if16.Mem_Busy = busy;
        if4.IF_ID_rs1 = rs1; if4.IF_ID_rs2 = rs2; if4.IF_ID_uses_rs2 = uses;
        if4.ID_EX_rd = rd; if4.ID_EX_MemRead = mr; if4.Branch_Taken = br; if4.Mem_Busy = busy;
    endtask

    task automatic check_ctl(input logic [6:0] exp);
        chk("ctl16", {25'd0, if16.PC_Write, if16.IF_ID_Write, if16.ID_EX_Write, if16.EX_MEM_Write,
                      if16.ID_EX_Bubble, if16.IF_ID_Flush, if16.ID_EX_Flush}, {25'd0, exp});
        chk("ctl4", {25'd0, if4.PC_Write, if4.IF_ID_Write, if4.ID_EX_Write, if4.EX_MEM_Write,
                     if4.ID_EX_Bubble, if4.IF_ID_Flush, if4.ID_EX_Flush}, {25'd0, exp});
    endtask

    task automatic check_regs();
        chk("state16", {30'd0, if16.state}, m_state);
        chk("state4", {30'd0, if4.state}, m_state);
        chk("stall16", {16'd0, if16.stall_count}, sat(m_stall, 16));
        chk("flush16", {16'd0, if16.flush_count}, sat(m_flush, 16));
        chk("stall4", {28'd0, if4.stall_count}, sat(m_stall, 4));
        chk("flush4", {28'd0, if4.flush_count}, sat(m_flush, 4));
        chk("err16", {31'd0, if16.hazard_error}, m_err);
        chk("err4", {31'd0, if4.hazard_error}, m_err);
    endtask

    task automatic step(input logic [4:0] rs1, input logic [4:0] rs2, input logic uses,
                        input logic [4:0] rd, input logic mr, input logic br, input logic busy);
        int a;
        @(negedge clk);
        drive(rs1, rs2, uses, rd, mr, br, busy);
        a = model_action(rs1, rs2, uses, rd, mr, br, busy);
        #1;
        check_ctl(exp_ctl(a));
        @(posedge clk);
        if (a == 1 && (m_state == 1 || m_state == 2)) m_err = 1;
        if (a == 1) m_stall++;
        if (a == 2) m_flush++;
        m_state = a;
        #1;
        check_regs();
    endtask

    // Asynchronous reset asserted mid-cycle, with whatever inputs are applied.
    task automatic do_reset();
        #2;
        reset = 1'b0;
        m_state = 0; m_stall = 0; m_flush = 0; m_err = 0;
        #1;
        check_regs();
        check_ctl(7'b0000_100);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        check_regs();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        do_reset();

        // load-use on rs1, then rs2 unused, then rd=0
        step(5, 0, 0, 5, 1, 0, 0);
        chk("req35_stall", {16'd0, if16.stall_count}, 1);
        step(0, 5, 0, 5, 1, 0, 0);
        step(0, 0, 1, 0, 1, 0, 0);
        step(7, 5, 1, 5, 1, 0, 0);

        // branch beats load-use
        do_reset();
        step(5, 0, 0, 5, 1, 1, 0);
        chk("req37_flush", {16'd0, if16.flush_count}, 1);

        // freeze masks a held branch, counted once on release
        do_reset();
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        // back-to-back load-use sets sticky error
        do_reset();
        step(3, 0, 0, 3, 1, 0, 0);
        step(3, 0, 0, 3, 1, 0, 0);
        chk("req39_err", {31'd0, if16.hazard_error}, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0);
        do_reset();

        // counter saturation, then reset while a stall is being driven
        for (int i = 0; i < 17; i++) step(9, 0, 0, 9, 1, 0, 0);
        chk("req40_sat4", {28'd0, if4.stall_count}, 15);
        @(negedge clk);
        drive(9, 0, 0, 9, 1, 0, 0);
        do_reset();

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) do_reset();
            step(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
